// File: rtl/ysyx_23060286_wb_scoreboard_arb_if.sv
// Writeback/scoreboard bus: IDU issue handshake, EXU and LSU writeback requests,
// register file write port and the busy scoreboard.
interface ysyx_23060286_wb_scoreboard_arb_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    localparam int AW = $clog2(NREG);

    logic            issue_valid;
    logic [AW-1:0]   issue_rs1;
    logic [AW-1:0]   issue_rs2;
    logic [AW-1:0]   issue_rd;
    logic            issue_wr;
    logic            issue_ready;

    logic            exu_valid;
    logic [AW-1:0]   exu_rd;
    logic [XLEN-1:0] exu_data;
    logic            exu_ready;

    logic            lsu_valid;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            rf_wen;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [NREG-1:0] busy_vec;

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        input  exu_valid, exu_rd, exu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_ready, exu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata, busy_vec
    );

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_wr,
        output exu_valid, exu_rd, exu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_ready, exu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata, busy_vec
    );
endinterface

// File: rtl/ysyx_23060286_wb_scoreboard_arb.sv
// Register file write-port owner: arbitrates EXU/LSU writeback and keeps the
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_23060286_wb_scoreboard_arb #(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int FIXED_PRIO = 0
) (
    input logic clk,
    input logic rst_n,
    ysyx_23060286_wb_scoreboard_arb_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            rr_lsu_q;
    logic            rf_wen_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    logic            both_valid;
    logic            grant_exu;
    logic            grant_lsu;
    logic            wb_go;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            issue_fire;

    assign both_valid = bus.exu_valid & bus.lsu_valid;

    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        if (both_valid) begin
            if ((FIXED_PRIO != 0) || rr_lsu_q) grant_lsu = 1'b1;
            else                               grant_exu = 1'b1;
        end else begin
            grant_exu = bus.exu_valid;
            grant_lsu = bus.lsu_valid;
        end
    end

    // A grant to x0 completes the handshake but never reaches the register file.
    always_comb begin
        wb_rd   = grant_lsu ? bus.lsu_rd   : bus.exu_rd;
        wb_data = grant_lsu ? bus.lsu_data : bus.exu_data;
        wb_go   = (grant_exu | grant_lsu) && (wb_rd != '0);
    end

    assign bus.exu_ready = grant_exu;
    assign bus.lsu_ready = grant_lsu;

    assign bus.issue_ready = ~busy_q[bus.issue_rs1] & ~busy_q[bus.issue_rs2]
                           & ~(bus.issue_wr & busy_q[bus.issue_rd]);
    assign issue_fire = bus.issue_valid & bus.issue_ready;

    // Clear on commit first so a same-index set overrides it.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
        if (issue_fire && bus.issue_wr && (bus.issue_rd != '0)) busy_d[bus.issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            rr_lsu_q   <= 1'b0;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            busy_q   <= busy_d;
            rf_wen_q <= wb_go;
            if (both_valid) rr_lsu_q <= ~rr_lsu_q;
            if (wb_go) begin
                rf_waddr_q <= wb_rd;
                rf_wdata_q <= wb_data;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_ysyx_23060286_wb_scoreboard_arb.sv
// Directed bench: a round-robin and a fixed-priority instance see identical stimulus;
// each comparison is an immediate assertion against hand-computed values.
module tb_ysyx_23060286_wb_scoreboard_arb;
    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    ysyx_23060286_wb_scoreboard_arb_if #(.XLEN(32), .NREG(32)) if_rr ();
    ysyx_23060286_wb_scoreboard_arb_if #(.XLEN(32), .NREG(32)) if_fp ();

    ysyx_23060286_wb_scoreboard_arb #(.XLEN(32), .NREG(32), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n), .bus(if_rr.slave)
    );
    ysyx_23060286_wb_scoreboard_arb #(.XLEN(32), .NREG(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .bus(if_fp.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    // Drives both instances identically, then lets combinational outputs settle.
    task automatic applyStimulus(input logic iv, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic wr,
                                 input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        if_rr.issue_valid = iv;  if_fp.issue_valid = iv;
        if_rr.issue_rs1   = rs1; if_fp.issue_rs1   = rs1;
        if_rr.issue_rs2   = rs2; if_fp.issue_rs2   = rs2;
        if_rr.issue_rd    = rd;  if_fp.issue_rd    = rd;
        if_rr.issue_wr    = wr;  if_fp.issue_wr    = wr;
        if_rr.exu_valid   = ev;  if_fp.exu_valid   = ev;
        if_rr.exu_rd      = erd; if_fp.exu_rd      = erd;
        if_rr.exu_data    = ed;  if_fp.exu_data    = ed;
        if_rr.lsu_valid   = lv;  if_fp.lsu_valid   = lv;
        if_rr.lsu_rd      = lrd; if_fp.lsu_rd      = lrd;
        if_rr.lsu_data    = ld;  if_fp.lsu_data    = ld;
        #1;
    endtask

    task automatic idle;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;

        // Reset held while inputs toggle randomly
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom_range(0, 1), 5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(0, 1),
                          $urandom_range(0, 1), 5'($urandom), $urandom,
                          $urandom_range(0, 1), 5'($urandom), $urandom);
            nextCycle();
            checkOutput("rst_rf_wen", 32'(if_rr.rf_wen), 32'h0);
            checkOutput("rst_busy", if_rr.busy_vec, 32'h0);
        end
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("rst_issue_ready", 32'(if_rr.issue_ready), 32'h1);
        checkOutput("rst_waddr", 32'(if_rr.rf_waddr), 32'h0);
        checkOutput("rst_wdata", if_rr.rf_wdata, 32'h0);

        idle();
        rst_n = 1'b1;
        nextCycle();
        idle();
        checkOutput("release_rf_wen", 32'(if_rr.rf_wen), 32'h0);

        // RAW hazard on x5 resolved by an EXU writeback
        applyStimulus(1, 0, 0, 5, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("issue_rd5_ready", 32'(if_rr.issue_ready), 32'h1);
        nextCycle();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("busy_x5_set", if_rr.busy_vec, 32'h0000_0020);
        checkOutput("raw_stall", 32'(if_rr.issue_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0);
        checkOutput("exu_x5_ready", 32'(if_rr.exu_ready), 32'h1);
        checkOutput("exu_x5_lsu_ready", 32'(if_rr.lsu_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("wb_x5_wen", 32'(if_rr.rf_wen), 32'h1);
        checkOutput("wb_x5_waddr", 32'(if_rr.rf_waddr), 32'd5);
        checkOutput("wb_x5_wdata", if_rr.rf_wdata, 32'hDEADBEEF);
        checkOutput("wb_x5_still_stall", 32'(if_rr.issue_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("x5_cleared", if_rr.busy_vec, 32'h0);
        checkOutput("x5_ready_n2", 32'(if_rr.issue_ready), 32'h1);
        checkOutput("x5_wen_drop", 32'(if_rr.rf_wen), 32'h0);

        // EXU(x3) and LSU(x4) contend for three cycles
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
        checkOutput("c1_rr_exu", 32'(if_rr.exu_ready), 32'h1);
        checkOutput("c1_rr_lsu", 32'(if_rr.lsu_ready), 32'h0);
        checkOutput("c1_fp_lsu", 32'(if_fp.lsu_ready), 32'h1);
        checkOutput("c1_fp_exu", 32'(if_fp.exu_ready), 32'h0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
        checkOutput("c2_rr_lsu", 32'(if_rr.lsu_ready), 32'h1);
        checkOutput("c2_rr_exu", 32'(if_rr.exu_ready), 32'h0);
        checkOutput("c2_fp_lsu", 32'(if_fp.lsu_ready), 32'h1);
        checkOutput("c2_rr_waddr", 32'(if_rr.rf_waddr), 32'd3);
        checkOutput("c2_rr_wdata", if_rr.rf_wdata, 32'h33);
        checkOutput("c2_fp_waddr", 32'(if_fp.rf_waddr), 32'd4);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
        checkOutput("c3_rr_exu", 32'(if_rr.exu_ready), 32'h1);
        checkOutput("c3_fp_lsu", 32'(if_fp.lsu_ready), 32'h1);
        checkOutput("c3_rr_waddr", 32'(if_rr.rf_waddr), 32'd4);
        checkOutput("c3_rr_wdata", if_rr.rf_wdata, 32'h44);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 0, 4, 32'h44);
        checkOutput("solo_rr_exu", 32'(if_rr.exu_ready), 32'h1);
        checkOutput("solo_fp_exu", 32'(if_fp.exu_ready), 32'h1);
        checkOutput("c4_rr_waddr", 32'(if_rr.rf_waddr), 32'd3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
        checkOutput("c5_rr_lsu", 32'(if_rr.lsu_ready), 32'h1);
        checkOutput("c5_rr_exu", 32'(if_rr.exu_ready), 32'h0);
        checkOutput("c5_fp_waddr", 32'(if_fp.rf_waddr), 32'd3);
        nextCycle();
        idle();
        checkOutput("c6_rr_waddr", 32'(if_rr.rf_waddr), 32'd4);
        checkOutput("nonbusy_wb_busy", if_rr.busy_vec, 32'h0);

        // Writeback to x0 is accepted but never written
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 32'h0);
        checkOutput("x0_exu_ready", 32'(if_rr.exu_ready), 32'h1);
        nextCycle();
        idle();
        checkOutput("x0_no_wen", 32'(if_rr.rf_wen), 32'h0);
        checkOutput("x0_busy", if_rr.busy_vec, 32'h0);

        // WAW hazard on x7
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("issue_rd7_ready", 32'(if_rr.issue_ready), 32'h1);
        nextCycle();
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("busy_x7_set", if_rr.busy_vec, 32'h0000_0080);
        checkOutput("waw_stall", 32'(if_rr.issue_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 32'h0, 1, 7, 32'h77);
        checkOutput("waw_lsu_ready", 32'(if_rr.lsu_ready), 32'h1);
        checkOutput("waw_stall_grant", 32'(if_rr.issue_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("wb_x7_wen", 32'(if_rr.rf_wen), 32'h1);
        checkOutput("wb_x7_wdata", if_rr.rf_wdata, 32'h77);
        checkOutput("waw_stall_commit", 32'(if_rr.issue_ready), 32'h0);
        nextCycle();
        applyStimulus(1, 0, 0, 7, 1, 0, 0, 32'h0, 0, 0, 32'h0);
        checkOutput("waw_release", 32'(if_rr.issue_ready), 32'h1);

        // Reset the cycle after a grant drops the in-flight write
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 1, 7, 32'hAA, 0, 0, 32'h0);
        checkOutput("busy_x7_again", if_rr.busy_vec, 32'h0000_0080);
        checkOutput("pre_rst_grant", 32'(if_rr.exu_ready), 32'h1);
        nextCycle();
        idle();
        checkOutput("pre_rst_wen", 32'(if_rr.rf_wen), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_wen", 32'(if_rr.rf_wen), 32'h0);
        checkOutput("mid_rst_busy", if_rr.busy_vec, 32'h0);
        checkOutput("mid_rst_waddr", 32'(if_rr.rf_waddr), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();
        checkOutput("post_rst_wen1", 32'(if_rr.rf_wen), 32'h0);
        nextCycle();
        checkOutput("post_rst_wen2", 32'(if_rr.rf_wen), 32'h0);
        checkOutput("post_rst_busy", if_rr.busy_vec, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
